// File: rtl/numeric_literal_parser_pkg.sv
// Shared types and ASCII constants for the numeric literal parser.
// The SIGN state exists only when NUMLIT_SIGNED_EN is defined.
package numlit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
`ifdef NUMLIT_SIGNED_EN
        ST_SIGN   = 3'd1,
`endif
        ST_PREFIX = 3'd2,
        ST_DIGITS = 3'd3,
        ST_RETURN = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        RADIX_DEC = 2'd0,
        RADIX_HEX = 2'd1,
        RADIX_BIN = 2'd2
    } radix_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_BAD_CHAR = 2'd1,
        ERR_OVERFLOW = 2'd2,
        ERR_EMPTY    = 2'd3
    } err_code_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_ONE   = 8'h31;
    localparam logic [7:0] ASCII_NINE  = 8'h39;
    localparam logic [7:0] ASCII_X_LO  = 8'h78;
    localparam logic [7:0] ASCII_X_UP  = 8'h58;
    localparam logic [7:0] ASCII_B_LO  = 8'h62;
    localparam logic [7:0] ASCII_B_UP  = 8'h42;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_A_LO  = 8'h61;
    localparam logic [7:0] ASCII_F_LO  = 8'h66;
    localparam logic [7:0] ASCII_A_UP  = 8'h41;
    localparam logic [7:0] ASCII_F_UP  = 8'h46;

endpackage

// File: rtl/numeric_literal_parser_if.sv
// Character-stream handshake and result bus of the numeric literal parser.
interface numeric_literal_parser_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             trigger_in;
    logic             char_valid_in;
    logic [7:0]       incoming_ascii;
    logic             busy_flag;
    logic             done_flag;
    logic             error_flag;
    logic [1:0]       err_code;
    logic [WIDTH-1:0] immediate;

    modport master (
        output trigger_in, char_valid_in, incoming_ascii,
        input  busy_flag, done_flag, error_flag, err_code, immediate
    );

    modport slave (
        input  trigger_in, char_valid_in, incoming_ascii,
        output busy_flag, done_flag, error_flag, err_code, immediate
    );
endinterface

// File: rtl/ascii_digit_decode.sv
// Combinational ASCII-to-digit decoder for decimal, hex and binary radices.
module ascii_digit_decode
    import numlit_pkg::*;
(
    input  logic [7:0] ch,
    input  radix_t     radix,
    output logic [3:0] digit,
    output logic       is_digit
);
    logic [7:0] off_num_s;
    logic [7:0] off_lo_s;
    logic [7:0] off_up_s;
    logic       is_num_s;

    assign off_num_s = ch - ASCII_ZERO;
    assign off_lo_s  = ch - ASCII_A_LO;
    assign off_up_s  = ch - ASCII_A_UP;
    assign is_num_s  = (ch >= ASCII_ZERO) && (ch <= ASCII_NINE);

    // Digit value and legality for the selected radix
    always_comb begin
        digit    = 4'd0;
        is_digit = 1'b0;
        case (radix)
            RADIX_BIN: begin
                if ((ch == ASCII_ZERO) || (ch == ASCII_ONE)) begin
                    digit    = off_num_s[3:0];
                    is_digit = 1'b1;
                end else begin
                    is_digit = 1'b0;
                end
            end
            RADIX_HEX: begin
                if (is_num_s) begin
                    digit    = off_num_s[3:0];
                    is_digit = 1'b1;
                end else if ((ch >= ASCII_A_LO) && (ch <= ASCII_F_LO)) begin
                    digit    = off_lo_s[3:0] + 4'd10;
                    is_digit = 1'b1;
                end else if ((ch >= ASCII_A_UP) && (ch <= ASCII_F_UP)) begin
                    digit    = off_up_s[3:0] + 4'd10;
                    is_digit = 1'b1;
                end else begin
                    is_digit = 1'b0;
                end
            end
            default: begin
                if (is_num_s) begin
                    digit    = off_num_s[3:0];
                    is_digit = 1'b1;
                end else begin
                    is_digit = 1'b0;
                end
            end
        endcase
    end
endmodule

// File: rtl/numeric_literal_parser.sv
// Parses a decimal / 0x-hex / 0b-binary ASCII literal into a WIDTH-bit immediate.
// Define NUMLIT_SIGNED_EN to accept a leading '-' (two's complement result).
module numeric_literal_parser
    import numlit_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter logic [7:0]  TERM_CHAR = 8'h27
) (
    input logic                     clk_in,
    input logic                     rst_in,
    numeric_literal_parser_if.slave bus
);
    state_t           state_r, state_nxt_s;
    radix_t           radix_r, radix_nxt_s;
    radix_t           dec_radix_s;
    err_code_t        code_r, code_nxt_s;
    logic [WIDTH-1:0] acc_r, acc_nxt_s;
    logic [WIDTH-1:0] imm_r, imm_nxt_s;
    logic [WIDTH-1:0] final_val_s;
    logic [WIDTH-1:0] first_acc_s;
    logic [WIDTH+3:0] acc_ext_s, dig_ext_s, sum_s;
    logic             have_dig_r, have_dig_nxt_s;
    logic             done_r, done_nxt_s;
    logic             error_r, error_nxt_s;
    logic             busy_r;
    logic             final_ovf_s;
    logic             sum_ovf_s;
    logic             dig_valid_s;
    logic             is_term_s;
    logic [3:0]       dig_s;
    logic [7:0]       ch_s;

    assign ch_s      = bus.incoming_ascii;
    assign is_term_s = (ch_s == TERM_CHAR);

    // Before the radix is known the first digit is always read as decimal
    assign dec_radix_s = (state_r == ST_DIGITS) ? radix_r : RADIX_DEC;

    ascii_digit_decode u_decode (
        .ch       (ch_s),
        .radix    (dec_radix_s),
        .digit    (dig_s),
        .is_digit (dig_valid_s)
    );

    assign acc_ext_s   = {4'b0000, acc_r};
    assign dig_ext_s   = {{WIDTH{1'b0}}, dig_s};
    assign first_acc_s = {{(WIDTH-4){1'b0}}, dig_s};
    assign sum_ovf_s   = |sum_s[WIDTH+3:WIDTH];

    // Accumulate one digit; four guard bits expose overflow
    always_comb begin
        sum_s = '0;
        case (radix_r)
            RADIX_HEX: sum_s = (acc_ext_s << 3'd4) + dig_ext_s;
            RADIX_BIN: sum_s = (acc_ext_s << 3'd1) + dig_ext_s;
            default:   sum_s = (acc_ext_s << 3'd3) + (acc_ext_s << 3'd1) + dig_ext_s;
        endcase
    end

`ifdef NUMLIT_SIGNED_EN
    localparam logic [WIDTH-1:0] NEG_MAG_MAX = {1'b1, {(WIDTH-1){1'b0}}};
    logic sign_r, sign_nxt_s;

    assign final_val_s = sign_r ? (~acc_r + {{(WIDTH-1){1'b0}}, 1'b1}) : acc_r;
    assign final_ovf_s = sign_r && (acc_r > NEG_MAG_MAX);
`else
    assign final_val_s = acc_r;
    assign final_ovf_s = 1'b0;
`endif

    // Next-state and result logic
    always_comb begin
        state_nxt_s    = state_r;
        radix_nxt_s    = radix_r;
        acc_nxt_s      = acc_r;
        imm_nxt_s      = imm_r;
        code_nxt_s     = code_r;
        have_dig_nxt_s = have_dig_r;
        done_nxt_s     = 1'b0;
        error_nxt_s    = 1'b0;
`ifdef NUMLIT_SIGNED_EN
        sign_nxt_s     = sign_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (bus.trigger_in) begin
                    code_nxt_s     = ERR_NONE;
                    acc_nxt_s      = '0;
                    radix_nxt_s    = RADIX_DEC;
                    have_dig_nxt_s = 1'b0;
`ifdef NUMLIT_SIGNED_EN
                    sign_nxt_s     = 1'b0;
`endif
                    if (ch_s == ASCII_ZERO) begin
                        state_nxt_s = ST_PREFIX;
                    end else if (dig_valid_s) begin
                        state_nxt_s    = ST_DIGITS;
                        acc_nxt_s      = first_acc_s;
                        have_dig_nxt_s = 1'b1;
                    end
`ifdef NUMLIT_SIGNED_EN
                    else if (ch_s == ASCII_MINUS) begin
                        state_nxt_s = ST_SIGN;
                        sign_nxt_s  = 1'b1;
                    end
`endif
                    else begin
                        state_nxt_s = ST_ERROR;
                        error_nxt_s = 1'b1;
                        code_nxt_s  = ERR_BAD_CHAR;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
`ifdef NUMLIT_SIGNED_EN
            ST_SIGN: begin
                if (!bus.char_valid_in) begin
                    state_nxt_s = ST_SIGN;
                end else if (ch_s == ASCII_ZERO) begin
                    state_nxt_s = ST_PREFIX;
                end else if (dig_valid_s) begin
                    state_nxt_s    = ST_DIGITS;
                    acc_nxt_s      = first_acc_s;
                    have_dig_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_ERROR;
                    error_nxt_s = 1'b1;
                    code_nxt_s  = ERR_BAD_CHAR;
                end
            end
`endif
            ST_PREFIX: begin
                if (!bus.char_valid_in) begin
                    state_nxt_s = ST_PREFIX;
                end else if ((ch_s == ASCII_X_LO) || (ch_s == ASCII_X_UP)) begin
                    state_nxt_s = ST_DIGITS;
                    radix_nxt_s = RADIX_HEX;
                end else if ((ch_s == ASCII_B_LO) || (ch_s == ASCII_B_UP)) begin
                    state_nxt_s = ST_DIGITS;
                    radix_nxt_s = RADIX_BIN;
                end else if (dig_valid_s) begin
                    state_nxt_s    = ST_DIGITS;
                    acc_nxt_s      = first_acc_s;
                    have_dig_nxt_s = 1'b1;
                end else if (is_term_s) begin
                    state_nxt_s = ST_RETURN;
                    done_nxt_s  = 1'b1;
                    imm_nxt_s   = final_val_s;
                end else begin
                    state_nxt_s = ST_ERROR;
                    error_nxt_s = 1'b1;
                    code_nxt_s  = ERR_BAD_CHAR;
                end
            end
            ST_DIGITS: begin
                if (!bus.char_valid_in) begin
                    state_nxt_s = ST_DIGITS;
                end else if (dig_valid_s) begin
                    if (sum_ovf_s) begin
                        state_nxt_s = ST_ERROR;
                        error_nxt_s = 1'b1;
                        code_nxt_s  = ERR_OVERFLOW;
                    end else begin
                        acc_nxt_s      = sum_s[WIDTH-1:0];
                        have_dig_nxt_s = 1'b1;
                    end
                end else if (is_term_s) begin
                    if (!have_dig_r) begin
                        state_nxt_s = ST_ERROR;
                        error_nxt_s = 1'b1;
                        code_nxt_s  = ERR_EMPTY;
                    end else if (final_ovf_s) begin
                        state_nxt_s = ST_ERROR;
                        error_nxt_s = 1'b1;
                        code_nxt_s  = ERR_OVERFLOW;
                    end else begin
                        state_nxt_s = ST_RETURN;
                        done_nxt_s  = 1'b1;
                        imm_nxt_s   = final_val_s;
                    end
                end else begin
                    state_nxt_s = ST_ERROR;
                    error_nxt_s = 1'b1;
                    code_nxt_s  = ERR_BAD_CHAR;
                end
            end
            ST_RETURN: state_nxt_s = ST_IDLE;
            ST_ERROR:  state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // State, accumulator and registered outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r    <= ST_IDLE;
            radix_r    <= RADIX_DEC;
            acc_r      <= '0;
            imm_r      <= '0;
            code_r     <= ERR_NONE;
            have_dig_r <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            busy_r     <= 1'b0;
`ifdef NUMLIT_SIGNED_EN
            sign_r     <= 1'b0;
`endif
        end else begin
            state_r    <= state_nxt_s;
            radix_r    <= radix_nxt_s;
            acc_r      <= acc_nxt_s;
            imm_r      <= imm_nxt_s;
            code_r     <= code_nxt_s;
            have_dig_r <= have_dig_nxt_s;
            done_r     <= done_nxt_s;
            error_r    <= error_nxt_s;
            busy_r     <= (state_nxt_s != ST_IDLE);
`ifdef NUMLIT_SIGNED_EN
            sign_r     <= sign_nxt_s;
`endif
        end
    end

    assign bus.busy_flag  = busy_r;
    assign bus.done_flag  = done_r;
    assign bus.error_flag = error_r;
    assign bus.err_code   = code_r;
    assign bus.immediate  = imm_r;
endmodule
